// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the control state encoding and the default operand width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_full_sub.sv
// Combinational 1-bit full subtractor: diff = a - b - bin, with borrow out.
module full_sub (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: d = a - b - b_in, one bit per clock, LSB first,
// with valid/ready handshakes on operands and result.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             ovf
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   d_sh_r;
    logic               brw_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               a_msb_r;
    logic               b_msb_r;
    logic [WIDTH-1:0]   d_r;
    logic               b_out_r;
    logic               ovf_r;
    logic               diff_s;
    logic               bout_s;
    logic               last_s;
    logic [WIDTH-1:0]   d_next_s;

    full_sub u_full_sub (
        .diff (diff_s),
        .bout (bout_s),
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .bin  (brw_r)
    );

    // The final result includes the bit being produced on the last RUN edge.
    assign d_next_s = {diff_s, d_sh_r[WIDTH-1:1]};
    assign last_s   = (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Handshake flags decode only the state register.
    always_comb begin
        in_ready  = (state_r == IDLE);
        out_valid = (state_r == DONE);
    end

    // Operand capture, serial shift/borrow chain and result load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            d_sh_r  <= '0;
            brw_r   <= 1'b0;
            cnt_r   <= '0;
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            d_r     <= '0;
            b_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        brw_r   <= b_in;
                        a_msb_r <= a[WIDTH-1];
                        b_msb_r <= b[WIDTH-1];
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    d_sh_r <= d_next_s;
                    brw_r  <= bout_s;
                    if (last_s) begin
                        // Overflow only when operand signs differ and the result sign leaves a's.
                        d_r     <= d_next_s;
                        b_out_r <= bout_s;
                        ovf_r   <= (a_msb_r ^ b_msb_r) & (d_next_s[WIDTH-1] ^ a_msb_r);
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    d_r <= d_r;
                end
                default: begin
                    d_r <= d_r;
                end
            endcase
        end
    end

    assign d     = d_r;
    assign b_out = b_out_r;
    assign ovf   = ovf_r;

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial N-bit subtractor. Computes d = a - b - b_in, one bit per clock, LSB first.
- Arithmetic inverse of the ripple-carry adder chain. Uses a single full-subtractor cell plus a borrow flip-flop instead of N cascaded cells.
- Sits on the datapath as a compact, area-cheap subtract unit.
- Uses a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  operands a, b, b_in are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- b_in  input  1  borrow in.
- out_valid  output  1  result d, b_out, ovf are valid.
- out_ready  input  1  consumer accepts the result.
- d  output  WIDTH  difference a - b - b_in, mod 2^WIDTH.
- b_out  output  1  borrow out. Set to 1 iff unsigned a < b + b_in.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset: clk and rst_n are fixed as above (one clock, synchronous active-low reset). rst_n=0 sampled at a rising edge produces, after that edge:
  - state=IDLE, out_valid=0, d=0, b_out=0, ovf=0;
  - internal shift registers, borrow flop and counter = 0.
- Reset asserted in RUN or DONE aborts the operation. No out_valid pulse is produced and the partial result is discarded.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=1, out_valid=0. If in_valid=1 at an edge:
    - latch a into a_sh, b into b_sh, b_in into the borrow flop;
    - record the operand MSBs for ovf;
    - cnt=0; go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge:
    - full-subtractor on (a_sh[0], b_sh[0], brw);
    - diff = a^b^bin;
    - bout = ~a&b | ~a&bin | b&bin;
    - d_sh <= {diff, d_sh[WIDTH-1:1]};
    - a_sh and b_sh shift right by 1;
    - brw <= bout;
    - cnt <= cnt+1.
  - RUN exit: on the edge where cnt==WIDTH-1, go to DONE. On that same edge, load d from the final d_sh value including the current diff bit, b_out from bout, and compute ovf = (a_msb != b_msb) & (d[WIDTH-1] != a_msb).
  - DONE: out_valid=1, in_ready=0. d, b_out and ovf are held stable while out_ready=0. On an edge with out_ready=1, go to IDLE.
- After DONE, d, b_out and ovf keep their last values in IDLE. They are only meaningful while out_valid=1.
- Latency: the acceptance edge is E. out_valid is high after edge E+WIDTH. Throughput is one operation per WIDTH+2 cycles minimum (accept, WIDTH RUN edges, handshake). Operations never overlap.
- in_valid in RUN or DONE is ignored. a, b and b_in are sampled only at the acceptance edge, so changing them later has no effect.
- out_ready in IDLE or RUN is ignored.
- cnt width is $clog2(WIDTH). The counter never wraps inside an operation.
- in_ready and out_valid are pure decodes of the state register (no combinational path from in_valid or out_ready).

Decomposition:
- Package serial_sub_pkg holds:
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - constant for the default WIDTH.
- Sub-module full_sub: combinational 1-bit full subtractor with ports diff, bout, a, b, bin, using the equations above. Instantiated once inside serial_sub.
- Control FSM, counter and shift registers stay in serial_sub.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, b_in=0, out_ready=1 -> d=0x02, b_out=0, ovf=0, out_valid rises exactly 8 edges after acceptance.
- a=0x03, b=0x05, b_in=0 -> d=0xFE, b_out=1, ovf=0. Then a=0x00, b=0x00, b_in=1 -> d=0xFF, b_out=1, ovf=0.
- a=0x80, b=0x01, b_in=0 -> d=0x7F, b_out=0, ovf=1. Then a=0x7F, b=0xFF -> d=0x80, b_out=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> out_valid, d, b_out and ovf stay stable; in_ready=0; new operands are not captured. After out_ready=1 for one edge -> IDLE, in_ready=1.
- Drive rst_n=0 for one edge at RUN cycle 4 -> next cycle state=IDLE, out_valid=0, d=0, b_out=0. A following operation 0x10-0x01 gives d=0x0F with correct latency.
- Random: 1000 operations with random a, b, b_in and random out_ready stalls -> d == (a-b-b_in) mod 256, and b_out and ovf match a scoreboard reference.
